// File: rtl/filter_peak_detector.sv
// filter_peak_detector: threshold-crossing pulse detector for the shaped filter
// stream. Tracks the maximum of each pulse and queues one result per pulse
// into a first-word-fall-through FIFO read with a valid/ready handshake.
// Optional feature macro: PEAK_TIMESTAMP_EN adds a free-running timestamp,
// stores it alongside each amplitude and exposes it on peak_time.

package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

module filter_peak_detector
  import package_settings::*;
#(
  parameter int DATA_W     = SIZE_FILTER_DATA,
  parameter int THRESHOLD  = 100,
  parameter int HOLDOFF    = 8,
  parameter int FIFO_DEPTH = 4
`ifdef PEAK_TIMESTAMP_EN
  ,
  parameter int TS_W       = 32
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  output logic signed [DATA_W-1:0] peak_amp,
`ifdef PEAK_TIMESTAMP_EN
  output logic        [TS_W-1:0]   peak_time,
`endif
  output logic                     peak_valid,
  input  logic                     peak_ready,
  output logic        [7:0]        lost_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [DATA_W-1:0] THR = DATA_W'(THRESHOLD);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Input pipeline: current sample, previous sample
  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W-1:0] x_p;

  // Detector state
  state_t                   state_r;
  state_t                   state_nxt;
  logic signed [DATA_W-1:0] max_r;
  logic signed [DATA_W-1:0] max_nxt;
  logic        [7:0]        hcnt_r;
  logic        [7:0]        hcnt_nxt;
  logic                     push_s;

  // Result FIFO storage and pointers (extra MSB separates full from empty)
  logic signed [DATA_W-1:0] mem_amp [FIFO_DEPTH];
  logic        [AW:0]       wr_ptr_r;
  logic        [AW:0]       rd_ptr_r;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic                     pop_s;
  logic                     push_ok_s;
  logic                     drop_s;

`ifdef PEAK_TIMESTAMP_EN
  localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_r;
  logic [TS_W-1:0] max_ts_r;
  logic [TS_W-1:0] max_ts_nxt;
  logic [TS_W-1:0] mem_ts [FIFO_DEPTH];

  // Free-running timestamp and the stamp of the sample held in x_r
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt <= '0;
      ts_r   <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_ONE;
      ts_r   <= ts_cnt;
    end
  end
`endif

  // Sample pipeline feeding the detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r <= '0;
      x_p <= '0;
    end else begin
      x_r <= filter_data;
      x_p <= x_r;
    end
  end

  // Detector next-state: crossing detection, max tracking, close and holdoff
  always_comb begin
    state_nxt  = state_r;
    max_nxt    = max_r;
    hcnt_nxt   = hcnt_r;
    push_s     = 1'b0;
`ifdef PEAK_TIMESTAMP_EN
    max_ts_nxt = max_ts_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // Only a genuine rising crossing opens a pulse
        if ((x_r > THR) && (x_p <= THR)) begin
          state_nxt  = ST_ARMED;
          max_nxt    = x_r;
`ifdef PEAK_TIMESTAMP_EN
          max_ts_nxt = ts_r;
`endif
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (x_r <= THR) begin
          push_s = 1'b1;
          if (HOLD_LOAD == 8'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_HOLD;
            hcnt_nxt  = HOLD_LOAD;
          end
        end else begin
          // Strictly greater: a plateau keeps its first timestamp
          if (x_r > max_r) begin
            max_nxt    = x_r;
`ifdef PEAK_TIMESTAMP_EN
            max_ts_nxt = ts_r;
`endif
          end else begin
            max_nxt = max_r;
          end
        end
      end
      ST_HOLD: begin
        if (hcnt_r <= 8'd1) begin
          state_nxt = ST_IDLE;
          hcnt_nxt  = 8'd0;
        end else begin
          hcnt_nxt = hcnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Detector state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      max_r    <= '0;
      hcnt_r   <= 8'd0;
`ifdef PEAK_TIMESTAMP_EN
      max_ts_r <= '0;
`endif
    end else begin
      state_r  <= state_nxt;
      max_r    <= max_nxt;
      hcnt_r   <= hcnt_nxt;
`ifdef PEAK_TIMESTAMP_EN
      max_ts_r <= max_ts_nxt;
`endif
    end
  end

  // FIFO status; a pop while full frees the slot a simultaneous push needs
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s        = peak_valid && peak_ready;
  assign push_ok_s    = push_s && (!fifo_full_s || pop_s);
  assign drop_s       = push_s && fifo_full_s && !pop_s;

  // FIFO storage and pointer update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_amp[i] <= '0;
`ifdef PEAK_TIMESTAMP_EN
        mem_ts[i]  <= '0;
`endif
      end
    end else begin
      if (push_ok_s) begin
        mem_amp[wr_ptr_r[AW-1:0]] <= max_r;
`ifdef PEAK_TIMESTAMP_EN
        mem_ts[wr_ptr_r[AW-1:0]]  <= max_ts_r;
`endif
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Saturating count of results dropped on a full FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lost_count <= 8'd0;
    end else if (drop_s && (lost_count != 8'hFF)) begin
      lost_count <= lost_count + 8'd1;
    end
  end

  // Head entry falls through to the outputs
  assign peak_valid = !fifo_empty_s;
  assign peak_amp   = mem_amp[rd_ptr_r[AW-1:0]];
`ifdef PEAK_TIMESTAMP_EN
  assign peak_time  = mem_ts[rd_ptr_r[AW-1:0]];
`endif

endmodule
